ifetch_rsp: RTL
===============

// Module: ifetch_rsp
// PURPOSE
//  Fetch responder: the memory-facing end of the PC generator's fetch interface. Takes each
//  fetch address/read-enable, runs it on the instruction bus (req/gnt, then rvalid), and
//  queues the returned word with its address for the IF/ID stage. Drops in-flight fetches on
//  jump/interrupt flush. Raises a stall back to the PC generator when it cannot accept.
// PARAMETERS
//  ADDR_W    32            fetch address width
//  DATA_W    32            instruction word width
//  DEPTH     2             response FIFO entries (power of 2, >=2)
//  INST_NOP  32'h00000001  inst_o value whenever inst_valid_o=0
// PORTS
//  clk           in   1       clock, all state on rising edge
//  rst           in   1       asynchronous, active-low reset
//  pc_i          in   ADDR_W  fetch address from PC generator
//  re_i          in   1       fetch request valid for pc_i this cycle
//  flush_i       in   1       jump/interrupt taken: discard queued and in-flight fetches
//  hold_i        in   1       IF/ID cannot take an instruction this cycle
//  fetch_stall_o out  1       pc_i/re_i not accepted this cycle; PC generator must hold
//  bus_req_o     out  1       bus request
//  bus_addr_o    out  ADDR_W  bus address, word aligned ([1:0]=0)
//  bus_gnt_i     in   1       bus accepted request (bus_req_o & bus_gnt_i)
//  bus_rvalid_i  in   1       read data valid, in request order, >=1 cycle after grant
//  bus_rdata_i   in   DATA_W  read data
//  inst_o        out  DATA_W  instruction to IF/ID
//  inst_addr_o   out  ADDR_W  address of inst_o
//  inst_valid_o  out  1       inst_o/inst_addr_o valid; consumed when !hold_i
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE, FIFO empty, kill=0. Outputs: bus_req_o=0, bus_addr_o=0,
//   inst_valid_o=0, inst_o=INST_NOP, inst_addr_o=0, fetch_stall_o=0. rst asserted mid-bus-
//   transaction abandons it; a later stray rvalid is ignored (kill=0, state IDLE).
//  FSM, at most one bus transaction outstanding:
//   IDLE: re_i & !flush_i & slots_free -> latch pc_i[ADDR_W-1:2]<<2 into addr reg, go REQ.
//   REQ:  bus_req_o=1, bus_addr_o=addr reg (stable until gnt). gnt -> RSP. flush_i in REQ
//         with gnt=0 -> drop request, IDLE. With gnt=1 -> RSP with kill=1.
//   RSP:  wait rvalid. kill=0: push {addr,rdata} to FIFO. kill=1: discard data, clear kill.
//         Either way go IDLE, or straight to REQ if re_i & !flush_i & slots_free the same
//         cycle (back-to-back). flush_i in RSP sets kill unless rvalid arrives that cycle,
//         in which case that data is discarded.
//  slots_free: FIFO count + (in-flight & !kill) < DEPTH, so every accepted fetch has a slot.
//  fetch_stall_o = re_i & !flush_i & !(state can latch this cycle), pure combinational.
//   flush_i always overrides: never stalls.
//  FIFO: head drives inst_o/inst_addr_o, inst_valid_o = !empty. Pop when valid & !hold_i.
//   Push and pop in the same cycle leave the count unchanged, and full+push+pop is legal.
//   flush_i empties the FIFO that cycle and inst_valid_o=0 next cycle. A push in the flush
//   cycle is discarded. Pointers wrap modulo DEPTH. Count is $clog2(DEPTH)+1 bits.
//  Latency: grant + rvalid in consecutive cycles -> inst_valid_o 1 cycle after rvalid.
//  Ordering: responses are delivered strictly in fetch order. No data bypasses the FIFO.
// STRUCTURE
//  Shared defines header: RstEnable, ReadEnable, ZeroWord, INST_NOP, FSM state encodings
//   (IF_IDLE/IF_REQ/IF_RSP).
//  One sub-module: ifetch_fifo (DEPTH x {ADDR_W+DATA_W}, push/pop/flush, empty/full/count).
//  Top holds FSM, addr reg, kill flag, and the stall/slot logic.
// TESTING
//  1 Reset: rst=0 with rvalid=1 -> all outputs at reset values. Release, re_i=0 -> nothing changes.
//  2 Stream: re_i=1, pc 0,4,8; gnt+1-cycle rvalid, rdata=A,B,C -> inst_o A@0,B@4,C@8 in order,
//    and fetch_stall_o only on request-issue cycles.
//  3 Hold/full: hold_i=1, DEPTH=2, fetch 0x10,0x14 -> FIFO full, fetch_stall_o=1 for pc 0x18,
//    no bus_req_o. Drop hold_i -> 0x10 then 0x14, then 0x18 is fetched.
//  4 Flush in RSP: pc 0x20 granted, flush_i=1 before rvalid, then pc 0x80 -> data for 0x20
//    never appears. First inst_addr_o=0x80.
//  5 Flush in REQ with gnt=0 -> request withdrawn, bus_req_o=0 next cycle, FIFO empty.
//  6 Simultaneous push+pop at full, and pc_i=0x103 -> count stays DEPTH; bus_addr_o=0x100.

Source files
------------

// File: rtl/ifetch_rsp_pkg.sv
// ifetch_rsp_pkg: shared constants and FSM encodings for the fetch responder
package ifetch_rsp_pkg;
  localparam logic RstEnable = 1'b0;
  localparam logic ReadEnable = 1'b1;
  localparam logic [31:0] ZeroWord = 32'h0000_0000;
  localparam logic [31:0] NopWord = 32'h0000_0001;
  localparam logic [1:0] IF_IDLE = 2'd0;
  localparam logic [1:0] IF_REQ = 2'd1;
  localparam logic [1:0] IF_RSP = 2'd2;
endpackage

// File: rtl/ifetch_rsp_fifo.sv
// ifetch_fifo: response queue of {addr,data} with push/pop/flush and occupancy count
module ifetch_fifo import ifetch_rsp_pkg::*; #(
  parameter int W = 64,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [W-1:0]               i_din,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output logic [W-1:0]               o_dout,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;
  logic w_full, w_wr, w_rd;
  assign o_empty = r_cnt == '0;
  assign w_full = r_cnt == (AW+1)'(DEPTH);
  assign w_rd = i_pop & !o_empty;
  // a pop frees the head slot this cycle, so full+push+pop is accepted
  assign w_wr = i_push & (!w_full | w_rd);
  assign o_dout = r_mem[r_rp];
  assign o_count = r_cnt;
  always_ff @(posedge clk)
    if (w_wr & !i_flush) r_mem[r_wp] <= i_din;
  always_ff @(posedge clk or negedge rst)
    if (rst == RstEnable) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + AW'(1);
      if (w_rd) r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_rd);
    end
endmodule

// File: rtl/ifetch_rsp.sv
// ifetch_rsp: runs PC-generator fetches on the req/gnt/rvalid bus and queues words for IF/ID
module ifetch_rsp import ifetch_rsp_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH = 2,
  parameter logic [DATA_W-1:0] INST_NOP = DATA_W'(NopWord)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              re_i,
  input  logic              flush_i,
  input  logic              hold_i,
  output logic              fetch_stall_o,
  output logic              bus_req_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  input  logic              bus_gnt_i,
  input  logic              bus_rvalid_i,
  input  logic [DATA_W-1:0] bus_rdata_i,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  output logic              inst_valid_o
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  logic [1:0] r_state;
  logic [ADDR_W-1:0] r_addr;
  logic r_kill;
  logic [ADDR_W+DATA_W-1:0] w_head;
  logic [CNT_W-1:0] w_count;
  logic w_empty, w_live, w_slots_free, w_rsp_done, w_can_latch, w_accept, w_push;
  // a live in-flight fetch already owns a slot, so count it against DEPTH
  assign w_live = (r_state != IF_IDLE) & !r_kill;
  assign w_slots_free = int'(w_count) + int'(w_live) < DEPTH;
  assign w_rsp_done = (r_state == IF_RSP) & bus_rvalid_i;
  assign w_can_latch = ((r_state == IF_IDLE) | w_rsp_done) & w_slots_free;
  assign w_accept = (re_i == ReadEnable) & !flush_i & w_can_latch;
  assign fetch_stall_o = (re_i == ReadEnable) & !flush_i & !w_can_latch;
  assign w_push = w_rsp_done & !r_kill & !flush_i;
  assign bus_req_o = r_state == IF_REQ;
  assign bus_addr_o = r_addr;
  assign inst_valid_o = !w_empty;
  assign inst_o = w_empty ? INST_NOP : w_head[DATA_W-1:0];
  assign inst_addr_o = w_empty ? '0 : w_head[ADDR_W+DATA_W-1:DATA_W];
  ifetch_fifo #(.W(ADDR_W + DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   ({r_addr, bus_rdata_i}),
    .i_pop   (!hold_i),
    .i_flush (flush_i),
    .o_dout  (w_head),
    .o_empty (w_empty),
    .o_count (w_count)
  );
  always_ff @(posedge clk or negedge rst)
    if (rst == RstEnable) begin
      r_state <= IF_IDLE;
      r_addr <= ADDR_W'(ZeroWord);
      r_kill <= 1'b0;
    end else begin
      if (w_accept) r_addr <= pc_i & ~ADDR_W'(3);
      case (r_state)
        IF_IDLE: r_state <= w_accept ? IF_REQ : IF_IDLE;
        IF_REQ: begin
          r_state <= bus_gnt_i ? IF_RSP : flush_i ? IF_IDLE : IF_REQ;
          if (bus_gnt_i) r_kill <= flush_i;
        end
        IF_RSP: begin
          r_state <= !bus_rvalid_i ? IF_RSP : w_accept ? IF_REQ : IF_IDLE;
          r_kill <= bus_rvalid_i ? 1'b0 : r_kill | flush_i;
        end
        default: r_state <= IF_IDLE;
      endcase
    end
endmodule
